date_counter: RTL and testbench
===============================

Name: date_counter

Overview:
- Holds the running UTC calendar date (day, month, two-digit year) for the GPS timekeeping chain.
- Sits directly downstream of the day-over check stage. It consumes the day-boundary pulse and that stage's month-over flag, and feeds the current day, month and 3-bit year code back into it.
- Accepts authoritative date loads from the NMEA/GPS date parser through a valid/ready handshake.
- Rollover decisions use internal month-length logic. The upstream month-over flag is only cross-checked against that logic.

Parameters:
- SETTLE_CYCLES, 1: cycles after any date change during which the upstream month-over cross-check is suppressed. This covers the registered latency of the day-over check. Legal range 1..3.
- YEAR_MAX, 99: maximum two-digit year. The year wraps to 0 after it.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hourOverSignal  in  1  one-cycle pulse marking the 23:59:59 -> 00:00:00 boundary (day advance).
- monthOverSignal  in  1  overSignal from the day-over check stage; meaningful only while hourOverSignal=1.
- loadValid  in  1  parser offers a date.
- loadReady  out  1  block can accept a load this cycle.
- loadDay  in  5  offered day, 1..31.
- loadMonth  in  4  offered month, 1..12.
- loadYear  in  7  offered two-digit year, 0..YEAR_MAX.
- day  out  5  current day.
- month  out  4  current month.
- year  out  7  current two-digit year.
- yearCode  out  3  year[2:0]; drives the day-over check leap test (code 0 or 4 means leap).
- dateValid  out  1  a valid date has been loaded since reset.
- dateUpdated  out  1  one-cycle pulse, coincident with new day/month/year values appearing.
- loadError  out  1  one-cycle pulse when a load is rejected.
- checkError  out  1  sticky flag: upstream month-over disagreed with internal logic.

Behaviour:
- Reset values: day=1, month=1, year=0, dateValid=0, loadReady=1, dateUpdated=0, loadError=0, checkError=0, state=UNSET, settle counter=0.
- States:
  - UNSET: no date yet. hourOverSignal is ignored and loadReady=1.
  - RUN: counting. loadReady=1.
  - SETTLE: entered for SETTLE_CYCLES cycles after any date change, then returns to RUN. loadReady=0.
- Load handshake: a load is accepted on a cycle where loadValid=1 and loadReady=1. The parser must hold its data stable until it is accepted.
- Load validation:
  - Valid when loadMonth is 1..12, loadYear <= YEAR_MAX, and 1 <= loadDay <= monthLength.
  - monthLength: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; month 2 gives 29 if loadYear[1:0]==0, else 28.
- Valid load:
  - Registers update at the next edge; dateUpdated=1 in that same cycle.
  - dateValid is set and the state moves to SETTLE.
  - Latency is 1 cycle from acceptance to outputs.
- Invalid load:
  - loadError=1 for one cycle (registered, 1 cycle after acceptance).
  - The date, dateValid and state are all unchanged.
- Rollover when hourOverSignal=1 in RUN or SETTLE:
  - If day < monthLength(month, year): day <= day+1.
  - Otherwise day <= 1 and the month advances. From month 12: month <= 1, and year <= 0 if year==YEAR_MAX, else year+1.
  - dateUpdated pulses and the state enters SETTLE (the settle counter restarts if already in SETTLE).
- Cross-check, RUN only:
  - When hourOverSignal=1 and monthOverSignal != (day==monthLength), set checkError.
  - checkError clears only on reset.
  - The check is suppressed in SETTLE and UNSET.
- Simultaneous load accept and hourOverSignal: the load wins and hourOverSignal is discarded. The parser date is authoritative. SETTLE is impossible here because loadReady=0 in that state.
- hourOverSignal in UNSET: no effect, no dateUpdated.
- Reset mid-SETTLE or with a pending load: all state returns to the reset values. A load offered on the same cycle as reset is not accepted.
- All outputs are registered except loadReady (decoded from state) and yearCode (wired from year).

Test Plan:
- Reset, then hourOverSignal pulse -> day=1, month=1, year=0, dateValid=0, no dateUpdated; loadReady=1.
- Load 28/2/23, wait 2 cycles, hourOverSignal with monthOverSignal=1 -> 1/3/23, dateUpdated pulse, checkError=0.
- Load 28/2/24, then hourOverSignal with monthOverSignal=0 -> 29/2/24. Two cycles later, hourOverSignal with monthOverSignal=1 -> 1/3/24.
- Load 31/12/99 (YEAR_MAX=99), then hourOverSignal -> 1/1/0 and yearCode=0. loadReady=0 for exactly SETTLE_CYCLES cycles after each change.
- Load 30/2/24 -> loadError pulse 1 cycle later; date stays at its prior value; dateValid unchanged.
- On 15/5/24 in RUN, hourOverSignal with monthOverSignal=1 -> 16/5/24 and checkError=1. Repeat the case inside SETTLE with checkError previously 0 -> checkError stays 0.

Source files
------------

// File: rtl/date_counter.sv
// -----------------------------------------------------------------------------
// date_counter
//
// Running UTC calendar date (day / month / two-digit year) for the GPS
// timekeeping chain. Sits downstream of the day-over check stage: it advances
// on the day-boundary pulse, and it sends the current day, month and 3-bit
// year code back to that stage. The NMEA/GPS parser can load an authoritative
// date through a valid/ready handshake.
//
// Rollover uses the month-length logic inside this block. The upstream
// month-over flag is only cross-checked against it.
//
// Parameters
//   SETTLE_CYCLES  cycles after a date change during which loads are refused
//                  and the upstream cross-check is suppressed (1..3)
//   YEAR_MAX       largest two-digit year; the year wraps to 0 after it
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   hourOverSignal   one-cycle day-advance pulse (23:59:59 -> 00:00:00)
//   monthOverSignal  upstream month-over flag, meaningful with hourOverSignal
//   loadValid        parser offers a date
//   loadReady        block accepts a load this cycle (decoded from state)
//   loadDay/Month/Year  offered date
//   day/month/year   current date (registered)
//   yearCode         year[2:0], used by the upstream leap test
//   dateValid        a valid date has been loaded since reset
//   dateUpdated      one-cycle pulse, coincident with new date values
//   loadError        one-cycle pulse, a load was rejected
//   checkError       sticky: upstream month-over disagreed with local logic
// -----------------------------------------------------------------------------
module date_counter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int YEAR_MAX      = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hourOverSignal,
  input  logic       monthOverSignal,
  input  logic       loadValid,
  output logic       loadReady,
  input  logic [4:0] loadDay,
  input  logic [3:0] loadMonth,
  input  logic [6:0] loadYear,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] yearCode,
  output logic       dateValid,
  output logic       dateUpdated,
  output logic       loadError,
  output logic       checkError
);

  typedef enum logic [1:0] {
    UNSET  = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [6:0] YEAR_MAX_L   = 7'(YEAR_MAX);
  // The counter holds the number of settle cycles still to go after the
  // current one, so a change loads SETTLE_CYCLES-1.
  localparam logic [1:0] SETTLE_START = 2'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] settle_cnt;

  // Days in a month. Any year with year[1:0]==0 is a leap year, which holds
  // for every two-digit year of the 2000-2099 GPS era. Out-of-range months
  // never reach the date registers, so their value here does not matter.
  function automatic logic [4:0] month_length(input logic [3:0] m,
                                              input logic [6:0] y);
    logic [4:0] len;
    len = 5'd31;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic       load_accept;
  logic       load_ok;
  logic       advance;
  logic       last_day;
  logic [4:0] cur_len;
  logic [4:0] load_len;
  logic [4:0] next_day;
  logic [3:0] next_month;
  logic [6:0] next_year;

  // SETTLE covers the registered latency of the upstream check, so a new date
  // is refused until the upstream stage has seen the previous one.
  assign loadReady   = (state != SETTLE);
  assign yearCode    = year[2:0];
  assign load_accept = loadValid && loadReady;

  assign cur_len  = month_length(month, year);
  assign load_len = month_length(loadMonth, loadYear);
  assign last_day = (day >= cur_len);

  assign load_ok = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) &&
                   (loadYear <= YEAR_MAX_L) &&
                   (loadDay != 5'd0) && (loadDay <= load_len);

  // An accepted load wins over a simultaneous day pulse. The parser date is
  // authoritative, so the pulse is dropped entirely (no cross-check either).
  assign advance = hourOverSignal && (state != UNSET) && !load_accept;

  // Next date on a day advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    next_day   = day + 5'd1;
    next_month = month;
    next_year  = year;
    if (last_day) begin
      next_day = 5'd1;
      if (month >= 4'd12) begin
        next_month = 4'd1;
        next_year  = (year >= YEAR_MAX_L) ? 7'd0 : year + 7'd1;
      end else begin
        next_month = month + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, date registers and registered flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      state       <= UNSET;
      settle_cnt  <= 2'd0;
      day         <= 5'd1;
      month       <= 4'd1;
      year        <= 7'd0;
      dateValid   <= 1'b0;
      dateUpdated <= 1'b0;
      loadError   <= 1'b0;
      checkError  <= 1'b0;
    end else begin
      dateUpdated <= 1'b0;
      loadError   <= 1'b0;

      if (load_accept) begin
        if (load_ok) begin
          day         <= loadDay;
          month       <= loadMonth;
          year        <= loadYear;
          dateValid   <= 1'b1;
          dateUpdated <= 1'b1;
          state       <= SETTLE;
          settle_cnt  <= SETTLE_START;
        end else begin
          // A rejected load leaves the date, dateValid and state untouched.
          loadError <= 1'b1;
        end
      end else if (advance) begin
        day         <= next_day;
        month       <= next_month;
        year        <= next_year;
        dateUpdated <= 1'b1;
        // The upstream flag is trusted for comparison only in RUN. In SETTLE
        // it may still reflect the date from before the last change.
        if ((state == RUN) && (monthOverSignal != (day == cur_len))) begin
          checkError <= 1'b1;
        end
        state      <= SETTLE;
        settle_cnt <= SETTLE_START;
      end else if (state == SETTLE) begin
        if (settle_cnt == 2'd0) begin
          state <= RUN;
        end else begin
          settle_cnt <= settle_cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// -----------------------------------------------------------------------------
// tb_date_counter
//
// Directed testbench for date_counter (SETTLE_CYCLES=1, YEAR_MAX=99). Inputs
// change 1 ns after a rising edge, and outputs are sampled at the same point,
// after the edge that acted on them. Each scenario task does its own checks.
// -----------------------------------------------------------------------------
module tb_date_counter;

  logic       clk;
  logic       reset;
  logic       hourOverSignal;
  logic       monthOverSignal;
  logic       loadValid;
  logic       loadReady;
  logic [4:0] loadDay;
  logic [3:0] loadMonth;
  logic [6:0] loadYear;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [2:0] yearCode;
  logic       dateValid;
  logic       dateUpdated;
  logic       loadError;
  logic       checkError;

  int checks = 0;
  int errors = 0;

  date_counter #(.SETTLE_CYCLES(1), .YEAR_MAX(99)) dut (
    .clk             (clk),
    .reset           (reset),
    .hourOverSignal  (hourOverSignal),
    .monthOverSignal (monthOverSignal),
    .loadValid       (loadValid),
    .loadReady       (loadReady),
    .loadDay         (loadDay),
    .loadMonth       (loadMonth),
    .loadYear        (loadYear),
    .day             (day),
    .month           (month),
    .year            (year),
    .yearCode        (yearCode),
    .dateValid       (dateValid),
    .dateUpdated     (dateUpdated),
    .loadError       (loadError),
    .checkError      (checkError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Offer a date for exactly one edge. The caller makes sure loadReady=1.
  task automatic do_load(input logic [4:0] d, input logic [3:0] m,
                         input logic [6:0] y);
    loadDay   = d;
    loadMonth = m;
    loadYear  = y;
    loadValid = 1'b1;
    tick();
    loadValid = 1'b0;
  endtask

  // One-edge day pulse with the given upstream month-over flag.
  task automatic day_pulse(input logic mo);
    hourOverSignal  = 1'b1;
    monthOverSignal = mo;
    tick();
    hourOverSignal  = 1'b0;
    monthOverSignal = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // A load offered during reset must not be taken.
    reset = 1'b1; loadValid = 1'b1;
    loadDay = 5'd10; loadMonth = 4'd10; loadYear = 7'd10;
    tick();
    reset = 1'b0; loadValid = 1'b0;
    checks++; if ({day, month, year} !== {5'd1, 4'd1, 7'd0}) begin errors++;
      $display("FAIL reset_date: got %0d/%0d/%0d expected 1/1/0", day, month, year); end
    checks++; if ({dateValid, dateUpdated, loadError, checkError} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got valid/upd/lerr/cerr=%b expected 0000",
               {dateValid, dateUpdated, loadError, checkError}); end
    checks++; if (loadReady !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", loadReady); end
    // A day pulse in UNSET is ignored.
    day_pulse(1'b1);
    checks++; if ({day, month, year} !== {5'd1, 4'd1, 7'd0}) begin errors++;
      $display("FAIL unset_pulse_date: got %0d/%0d/%0d expected 1/1/0", day, month, year); end
    checks++; if ({dateValid, dateUpdated, loadReady} !== 3'b001) begin errors++;
      $display("FAIL unset_pulse_flags: got valid/upd/ready=%b expected 001",
               {dateValid, dateUpdated, loadReady}); end
  endtask

  task automatic test_nonleap_feb();
    apply_reset();
    do_load(5'd28, 4'd2, 7'd23);
    checks++; if ({day, month, year} !== {5'd28, 4'd2, 7'd23}) begin errors++;
      $display("FAIL load_date: got %0d/%0d/%0d expected 28/2/23", day, month, year); end
    checks++; if ({dateValid, dateUpdated, loadReady} !== 3'b110) begin errors++;
      $display("FAIL load_flags: got valid/upd/ready=%b expected 110",
               {dateValid, dateUpdated, loadReady}); end
    tick();
    tick();
    checks++; if ({dateUpdated, loadReady} !== 2'b01) begin errors++;
      $display("FAIL load_idle: got upd/ready=%b expected 01", {dateUpdated, loadReady}); end
    day_pulse(1'b1);
    checks++; if ({day, month, year} !== {5'd1, 4'd3, 7'd23}) begin errors++;
      $display("FAIL nonleap_roll: got %0d/%0d/%0d expected 1/3/23", day, month, year); end
    checks++; if ({dateUpdated, checkError} !== 2'b10) begin errors++;
      $display("FAIL nonleap_flags: got upd/cerr=%b expected 10", {dateUpdated, checkError}); end
  endtask

  task automatic test_leap_feb();
    apply_reset();
    do_load(5'd28, 4'd2, 7'd24);
    tick();
    day_pulse(1'b0);
    checks++; if ({day, month, year} !== {5'd29, 4'd2, 7'd24}) begin errors++;
      $display("FAIL leap_29: got %0d/%0d/%0d expected 29/2/24", day, month, year); end
    tick();
    tick();
    day_pulse(1'b1);
    checks++; if ({day, month, year} !== {5'd1, 4'd3, 7'd24}) begin errors++;
      $display("FAIL leap_roll: got %0d/%0d/%0d expected 1/3/24", day, month, year); end
    checks++; if (checkError !== 1'b0) begin errors++;
      $display("FAIL leap_cerr: got %b expected 0", checkError); end
  endtask

  task automatic test_month_30();
    apply_reset();
    do_load(5'd30, 4'd4, 7'd21);
    tick();
    day_pulse(1'b1);
    checks++; if ({day, month, year, checkError} !== {5'd1, 4'd5, 7'd21, 1'b0}) begin errors++;
      $display("FAIL apr_roll: got %0d/%0d/%0d cerr=%b expected 1/5/21 cerr=0",
               day, month, year, checkError); end
  endtask

  task automatic test_year_wrap();
    apply_reset();
    do_load(5'd31, 4'd12, 7'd99);
    checks++; if (loadReady !== 1'b0) begin errors++;
      $display("FAIL wrap_settle_load: got ready=%b expected 0", loadReady); end
    tick();
    checks++; if (loadReady !== 1'b1) begin errors++;
      $display("FAIL wrap_run_load: got ready=%b expected 1", loadReady); end
    day_pulse(1'b1);
    checks++; if ({day, month, year} !== {5'd1, 4'd1, 7'd0}) begin errors++;
      $display("FAIL wrap_date: got %0d/%0d/%0d expected 1/1/0", day, month, year); end
    checks++; if ({yearCode, dateUpdated, loadReady} !== {3'd0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL wrap_flags: got code=%0d upd=%b ready=%b expected 0 1 0",
               yearCode, dateUpdated, loadReady); end
    tick();
    checks++; if ({dateUpdated, loadReady, checkError} !== 3'b010) begin errors++;
      $display("FAIL wrap_after: got upd/ready/cerr=%b expected 010",
               {dateUpdated, loadReady, checkError}); end
  endtask

  // Runs straight after test_year_wrap: RUN state on 1/1/0.
  task automatic test_invalid_load();
    do_load(5'd30, 4'd2, 7'd24);
    checks++; if (loadError !== 1'b1) begin errors++;
      $display("FAIL bad_feb30_err: got %b expected 1", loadError); end
    checks++; if ({day, month, year} !== {5'd1, 4'd1, 7'd0}) begin errors++;
      $display("FAIL bad_feb30_date: got %0d/%0d/%0d expected 1/1/0", day, month, year); end
    checks++; if ({dateValid, dateUpdated, loadReady} !== 3'b101) begin errors++;
      $display("FAIL bad_feb30_flags: got valid/upd/ready=%b expected 101",
               {dateValid, dateUpdated, loadReady}); end
    tick();
    checks++; if (loadError !== 1'b0) begin errors++;
      $display("FAIL bad_err_pulse: got %b expected 0", loadError); end
    do_load(5'd29, 4'd2, 7'd23);
    checks++; if (loadError !== 1'b1) begin errors++;
      $display("FAIL bad_feb29_nonleap: got %b expected 1", loadError); end
    do_load(5'd0, 4'd5, 7'd24);
    checks++; if (loadError !== 1'b1) begin errors++;
      $display("FAIL bad_day0: got %b expected 1", loadError); end
    do_load(5'd1, 4'd13, 7'd24);
    checks++; if (loadError !== 1'b1) begin errors++;
      $display("FAIL bad_month13: got %b expected 1", loadError); end
    do_load(5'd1, 4'd1, 7'd100);
    checks++; if (loadError !== 1'b1) begin errors++;
      $display("FAIL bad_year100: got %b expected 1", loadError); end
    do_load(5'd31, 4'd6, 7'd24);
    checks++; if ({loadError, day, month, year} !== {1'b1, 5'd1, 4'd1, 7'd0}) begin errors++;
      $display("FAIL bad_jun31: got err=%b %0d/%0d/%0d expected 1 1/1/0",
               loadError, day, month, year); end
    // A rejected load in UNSET leaves dateValid low.
    apply_reset();
    do_load(5'd31, 4'd4, 7'd24);
    checks++; if ({loadError, dateValid, dateUpdated} !== 3'b100) begin errors++;
      $display("FAIL bad_unset: got err/valid/upd=%b expected 100",
               {loadError, dateValid, dateUpdated}); end
  endtask

  task automatic test_check_error();
    apply_reset();
    do_load(5'd15, 4'd5, 7'd24);
    tick();
    day_pulse(1'b1);
    checks++; if ({day, month, year, checkError} !== {5'd16, 4'd5, 7'd24, 1'b1}) begin errors++;
      $display("FAIL cerr_run: got %0d/%0d/%0d cerr=%b expected 16/5/24 cerr=1",
               day, month, year, checkError); end
    tick();
    tick();
    checks++; if (checkError !== 1'b1) begin errors++;
      $display("FAIL cerr_sticky: got %b expected 1", checkError); end
    apply_reset();
    checks++; if (checkError !== 1'b0) begin errors++;
      $display("FAIL cerr_reset: got %b expected 0", checkError); end
    // Same disagreement inside SETTLE is not flagged and restarts SETTLE.
    do_load(5'd15, 4'd5, 7'd24);
    day_pulse(1'b1);
    checks++; if ({day, month, year, checkError} !== {5'd16, 4'd5, 7'd24, 1'b0}) begin errors++;
      $display("FAIL cerr_settle: got %0d/%0d/%0d cerr=%b expected 16/5/24 cerr=0",
               day, month, year, checkError); end
    checks++; if ({dateUpdated, loadReady} !== 2'b10) begin errors++;
      $display("FAIL settle_restart: got upd/ready=%b expected 10", {dateUpdated, loadReady}); end
    tick();
    checks++; if (loadReady !== 1'b1) begin errors++;
      $display("FAIL settle_exit: got ready=%b expected 1", loadReady); end
  endtask

  task automatic test_load_vs_hourover();
    apply_reset();
    do_load(5'd20, 4'd6, 7'd24);
    tick();
    hourOverSignal = 1'b1;
    monthOverSignal = 1'b1;
    do_load(5'd10, 4'd7, 7'd24);
    hourOverSignal = 1'b0;
    monthOverSignal = 1'b0;
    checks++; if ({day, month, year} !== {5'd10, 4'd7, 7'd24}) begin errors++;
      $display("FAIL load_wins: got %0d/%0d/%0d expected 10/7/24", day, month, year); end
    checks++; if ({dateUpdated, checkError} !== 2'b10) begin errors++;
      $display("FAIL load_wins_flags: got upd/cerr=%b expected 10", {dateUpdated, checkError}); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    loadDay = 5'd5; loadMonth = 4'd8; loadYear = 7'd24;
    loadValid = 1'b1;
    tick();
    checks++; if ({day, month, year, loadReady} !== {5'd5, 4'd8, 7'd24, 1'b0}) begin errors++;
      $display("FAIL b2b_first: got %0d/%0d/%0d ready=%b expected 5/8/24 ready=0",
               day, month, year, loadReady); end
    // Parser presents the next date and holds it while SETTLE refuses it.
    loadDay = 5'd6; loadMonth = 4'd9; loadYear = 7'd25;
    tick();
    checks++; if ({day, month, year, dateUpdated, loadReady} !==
                  {5'd5, 4'd8, 7'd24, 1'b0, 1'b1}) begin errors++;
      $display("FAIL b2b_held: got %0d/%0d/%0d upd=%b ready=%b expected 5/8/24 0 1",
               day, month, year, dateUpdated, loadReady); end
    tick();
    loadValid = 1'b0;
    checks++; if ({day, month, year, dateUpdated} !== {5'd6, 4'd9, 7'd25, 1'b1}) begin errors++;
      $display("FAIL b2b_second: got %0d/%0d/%0d upd=%b expected 6/9/25 1",
               day, month, year, dateUpdated); end
  endtask

  initial begin
    reset           = 1'b1;
    hourOverSignal  = 1'b0;
    monthOverSignal = 1'b0;
    loadValid       = 1'b0;
    loadDay         = 5'd0;
    loadMonth       = 4'd0;
    loadYear        = 7'd0;
    tick();
    test_reset();
    test_nonleap_feb();
    test_leap_feb();
    test_month_30();
    test_year_wrap();
    test_invalid_load();
    test_check_error();
    test_load_vs_hourover();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
